// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through receive FIFO.
// Serial input is double-synchronised; start/stop bits are checked and
// errors are reported through sticky overrun / frame_err flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               core_clk,
  input  logic                               core_rst_n,
  input  logic                               ser_rx,
  output logic [7:0]                         rd_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               rx_busy,
  output logic                               overrun,
  output logic                               frame_err,
  input  logic                               clear_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic              sync1_q, sync2_q;
  logic              rx_s;
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              sample_s, push_s, ferr_set_s;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_s, pop_s, push_ok_s, ovr_set_s;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  assign rx_s     = sync2_q;
  assign sample_s = (baud_q == BAUD_W'(0));

  // Two-flop synchroniser for the asynchronous serial line, idles high.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ser_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM: next state, baud counter reload/countdown, bit shifting.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          baud_d  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
          state_d = ST_START;
        end else begin
          baud_d  = BAUD_W'(0);
        end
      end
      ST_START: begin
        if (sample_s) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            baud_d    = BAUD_W'(CLKS_PER_BIT - 1);
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          // LSB arrives first, so shift right; after 8 bits it sits in bit 0.
          shift_d = {rx_s, shift_q[7:1]};
          baud_d  = BAUD_W'(CLKS_PER_BIT - 1);
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (sample_s) begin
          // Leaving at mid-stop-bit lets the next start edge be caught immediately.
          if (rx_s) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set_s = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = BAUD_W'(0);
      end
    endcase
  end

  // FIFO bookkeeping, sticky error flags and registered output values.
  always_comb begin
    full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    pop_s     = (count_q != CNT_W'(0)) & rd_ready;
    push_ok_s = push_s & (~full_s | pop_s);
    ovr_set_s = push_s & full_s & ~pop_s;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle beats the clear request.
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clear_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (ferr_set_s) begin
      frame_err_d = 1'b1;
    end else if (clear_err) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
    rd_data_d  = mem_d[rd_ptr_d];
    rd_valid_d = (count_d != CNT_W'(0));
    busy_d     = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= ST_IDLE;
      baud_q      <= BAUD_W'(0);
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= CNT_W'(0);
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_count = count_q;
  assign rx_busy    = busy_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at default parameters.
module tb_uart_rx_fifo;

  localparam int CPB = 217;

  logic       core_clk = 1'b0;
  logic       core_rst_n = 1'b0;
  logic       ser_rx = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       rx_busy;
  logic       overrun;
  logic       frame_err;
  logic       clear_err = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo dut (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .ser_rx     (ser_rx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .fifo_count (fifo_count),
    .rx_busy    (rx_busy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .clear_err  (clear_err)
  );

  // 40 ns period, 25 MHz
  always #20 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame; stop_bit selects a good (1) or broken (0) stop bit.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(posedge core_clk);
    #1 ser_rx = 1'b0;
    repeat (CPB) @(posedge core_clk);
    for (int i = 0; i < 8; i++) begin
      #1 ser_rx = d[i];
      repeat (CPB) @(posedge core_clk);
    end
    #1 ser_rx = stop_bit;
    repeat (CPB) @(posedge core_clk);
    #1 ser_rx = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge core_clk);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    @(posedge core_clk);
    #1 rd_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge core_clk);
    #1 clear_err = 1'b1;
    @(posedge core_clk);
    #1 clear_err = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    #5;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    repeat (3) @(posedge core_clk);
    #1 core_rst_n = 1'b1;
    repeat (5) @(posedge core_clk);

    // 1: single byte, latency bound, then pop
    n = 0;
    fork
      send_byte(8'h68, 1'b1);
      begin
        @(posedge core_clk);
        while (!rd_valid && n <= 10 * CPB + 4) begin
          @(negedge core_clk);
          n++;
        end
      end
    join
    chk("t1_latency", 32'(n <= 10 * CPB + 4), 32'd1);
    @(negedge core_clk);
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_data", 32'(rd_data), 32'h68);
    chk("t1_count", 32'(fifo_count), 32'd1);
    rd_ready = 1'b1;
    @(posedge core_clk);
    #1 rd_ready = 1'b0;
    @(negedge core_clk);
    chk("t1_count_pop", 32'(fifo_count), 32'd0);
    chk("t1_valid_pop", 32'(rd_valid), 32'd0);

    // 2: 50-cycle glitch is rejected at the start-bit sample
    @(posedge core_clk);
    #1 ser_rx = 1'b0;
    repeat (50) @(posedge core_clk);
    #1 ser_rx = 1'b1;
    repeat (300) @(posedge core_clk);
    @(negedge core_clk);
    chk("t2_count", 32'(fifo_count), 32'd0);
    chk("t2_busy", 32'(rx_busy), 32'd0);
    chk("t2_ovr", 32'(overrun), 32'd0);
    chk("t2_ferr", 32'(frame_err), 32'd0);

    // 3: broken stop bit
    send_byte(8'h55, 1'b0);
    repeat (20) @(posedge core_clk);
    @(negedge core_clk);
    chk("t3_ferr", 32'(frame_err), 32'd1);
    chk("t3_count", 32'(fifo_count), 32'd0);
    chk("t3_busy", 32'(rx_busy), 32'd0);
    pulse_clear();
    @(negedge core_clk);
    chk("t3_ferr_clr", 32'(frame_err), 32'd0);

    // 4: nine back-to-back bytes with no reader -> overrun
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1);
    end
    repeat (20) @(posedge core_clk);
    @(negedge core_clk);
    chk("t4_count", 32'(fifo_count), 32'd8);
    chk("t4_ovr", 32'(overrun), 32'd1);
    chk("t4_ferr", 32'(frame_err), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      pop_chk("t4_drain", 8'(i));
    end
    @(negedge core_clk);
    chk("t4_empty", 32'(rd_valid), 32'd0);
    pulse_clear();
    @(negedge core_clk);
    chk("t4_ovr_clr", 32'(overrun), 32'd0);

    // 5: full FIFO, pop exactly on the stop-bit sample of the next byte
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b1);
    end
    repeat (20) @(posedge core_clk);
    @(negedge core_clk);
    chk("t5_full", 32'(fifo_count), 32'd8);
    fork
      send_byte(8'h0A, 1'b1);
      begin
        // start edge driven after edge P0; stop sample lands on edge P0+2064
        @(posedge core_clk);
        repeat (2063) @(posedge core_clk);
        @(negedge core_clk);
        chk("t5_pre_count", 32'(fifo_count), 32'd8);
        chk("t5_pre_busy", 32'(rx_busy), 32'd1);
        rd_ready = 1'b1;
        @(posedge core_clk);
        #1 rd_ready = 1'b0;
        @(negedge core_clk);
        chk("t5_post_count", 32'(fifo_count), 32'd8);
        chk("t5_post_ovr", 32'(overrun), 32'd0);
      end
    join
    for (int i = 2; i <= 8; i++) begin
      pop_chk("t5_drain", 8'(i));
    end
    pop_chk("t5_last", 8'h0A);
    @(negedge core_clk);
    chk("t5_empty", 32'(fifo_count), 32'd0);

    // 6: reset in the middle of 0xA5, then a clean 0x3C
    @(posedge core_clk);
    #1 ser_rx = 1'b0;
    repeat (CPB) @(posedge core_clk);
    for (int i = 0; i < 3; i++) begin
      #1 ser_rx = i[0] ? 1'b0 : 1'b1;
      repeat (CPB) @(posedge core_clk);
    end
    @(negedge core_clk);
    chk("t6_busy_mid", 32'(rx_busy), 32'd1);
    core_rst_n = 1'b0;
    #5;
    chk("t6_rst_busy", 32'(rx_busy), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    ser_rx = 1'b1;
    repeat (4) @(posedge core_clk);
    #1 core_rst_n = 1'b1;
    repeat (10) @(posedge core_clk);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(posedge core_clk);
    @(negedge core_clk);
    chk("t6_count", 32'(fifo_count), 32'd1);
    chk("t6_data", 32'(rd_data), 32'h3C);
    chk("t6_ovr", 32'(overrun), 32'd0);
    chk("t6_ferr", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
